// File: rtl/pipe_hazard_ctl_if.sv
// Hazard controller handshake bundle: ID-stage instruction info in,
// stall/flush controls and status out.
interface pipe_hazard_ctl_if;
    logic        iw_id_valid;
    logic        iw_id_has_src_gp;
    logic [3:0]  iw_id_src_gp;
    logic        iw_id_tgt_gp_we;
    logic [3:0]  iw_id_tgt_gp;
    logic        iw_id_has_src_sr;
    logic [1:0]  iw_id_src_sr;
    logic        iw_id_tgt_sr_we;
    logic [1:0]  iw_id_tgt_sr;
    logic        iw_id_is_load;
    logic        iw_ex_branch_taken;
    logic        iw_mem_busy;
    logic        ow_stall_if;
    logic        ow_stall_id;
    logic        ow_flush_if;
    logic        ow_flush_id;
    logic [1:0]  ow_state;
    logic [15:0] ow_stall_cnt;

    modport master (
        output iw_id_valid, iw_id_has_src_gp, iw_id_src_gp,
        output iw_id_tgt_gp_we, iw_id_tgt_gp,
        output iw_id_has_src_sr, iw_id_src_sr,
        output iw_id_tgt_sr_we, iw_id_tgt_sr,
        output iw_id_is_load, iw_ex_branch_taken, iw_mem_busy,
        input  ow_stall_if, ow_stall_id, ow_flush_if, ow_flush_id,
        input  ow_state, ow_stall_cnt
    );

    modport slave (
        input  iw_id_valid, iw_id_has_src_gp, iw_id_src_gp,
        input  iw_id_tgt_gp_we, iw_id_tgt_gp,
        input  iw_id_has_src_sr, iw_id_src_sr,
        input  iw_id_tgt_sr_we, iw_id_tgt_sr,
        input  iw_id_is_load, iw_ex_branch_taken, iw_mem_busy,
        output ow_stall_if, ow_stall_id, ow_flush_if, ow_flush_id,
        output ow_state, ow_stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctl.sv
// Pipeline hazard controller: scoreboard, stall/flush FSM, stall counter.
// Option HAZARD_FWD_EN: stall only on young loads (ALU results forwarded).
module pipe_hazard_ctl (
    input logic              iw_clk,
    input logic              iw_rst,
    pipe_hazard_ctl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HAZ   = 2'd1,
        FLUSH = 2'd2,
        MEMW  = 2'd3
    } state_t;

    state_t      state;
    logic [2:0]  gp_cnt [16];
    logic        gp_ld  [16];
    logic [2:0]  sr_cnt [4];
    logic        sr_ld  [4];
    logic [15:0] stall_cnt;

    logic [15:0] gp_blk;
    logic [3:0]  sr_blk;
    logic [15:0] gp_hit;
    logic [3:0]  sr_hit;
    logic        hazard;
    logic        flush;
    logic        stall;
    logic        issue;
    logic        advance;
    logic [2:0]  new_cnt;

    // Per-entry stall rule; a source matching its own target cannot block
    // because the scoreboard only changes after the instruction issues.
    always_comb begin
        gp_blk = '0;
        sr_blk = '0;
`ifdef HAZARD_FWD_EN
        for (int i = 0; i < 16; i++)
            gp_blk[i] = gp_ld[i] && (gp_cnt[i] >= 3'd3);
        for (int i = 0; i < 4; i++)
            sr_blk[i] = sr_ld[i] && (sr_cnt[i] >= 3'd3);
`else
        for (int i = 0; i < 16; i++)
            gp_blk[i] = (gp_cnt[i] != 3'd0);
        for (int i = 0; i < 4; i++)
            sr_blk[i] = (sr_cnt[i] != 3'd0);
`endif
    end

    // Stall/flush decode; branch beats memory wait beats data hazard.
    always_comb begin
        hazard = hz.iw_id_valid &&
                 ((hz.iw_id_has_src_gp && gp_blk[hz.iw_id_src_gp]) ||
                  (hz.iw_id_has_src_sr && sr_blk[hz.iw_id_src_sr]));
        flush   = !iw_rst &&
                  (hz.iw_ex_branch_taken || state == FLUSH);
        stall   = !iw_rst && !flush && (hz.iw_mem_busy || hazard);
        issue   = hz.iw_id_valid && !stall && !flush && !iw_rst;
        advance = !(hz.iw_mem_busy && !flush);
        new_cnt = hz.iw_id_is_load ? 3'd4 : 3'd3;
        gp_hit  = '0;
        sr_hit  = '0;
        for (int i = 0; i < 16; i++)
            gp_hit[i] = issue && hz.iw_id_tgt_gp_we &&
                        (hz.iw_id_tgt_gp == 4'(i));
        for (int i = 0; i < 4; i++)
            sr_hit[i] = issue && hz.iw_id_tgt_sr_we &&
                        (hz.iw_id_tgt_sr == 2'(i));
    end

    // Scoreboard: reload on issue, otherwise count down unless memory holds.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            for (int i = 0; i < 16; i++) begin
                gp_cnt[i] <= 3'd0;
                gp_ld[i]  <= 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                sr_cnt[i] <= 3'd0;
                sr_ld[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (gp_hit[i]) begin
                    gp_cnt[i] <= new_cnt;
                    gp_ld[i]  <= hz.iw_id_is_load;
                end else if (advance && gp_cnt[i] != 3'd0) begin
                    gp_cnt[i] <= gp_cnt[i] - 3'd1;
                    if (gp_cnt[i] == 3'd1) gp_ld[i] <= 1'b0;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (sr_hit[i]) begin
                    sr_cnt[i] <= new_cnt;
                    sr_ld[i]  <= hz.iw_id_is_load;
                end else if (advance && sr_cnt[i] != 3'd0) begin
                    sr_cnt[i] <= sr_cnt[i] - 3'd1;
                    if (sr_cnt[i] == 3'd1) sr_ld[i] <= 1'b0;
                end
            end
        end
    end

    // Control FSM; FLUSH lasts one registered cycle after the branch cycle.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            state <= RUN;
        end else if (state == FLUSH) begin
            state <= hz.iw_ex_branch_taken ? FLUSH : RUN;
        end else begin
            if (hz.iw_ex_branch_taken) state <= FLUSH;
            else if (hz.iw_mem_busy)   state <= MEMW;
            else if (hazard)           state <= HAZ;
            else                       state <= RUN;
        end
    end

    // Saturating count of cycles with ID held.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst)
            stall_cnt <= 16'd0;
        else if (stall && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end

    assign hz.ow_stall_if  = stall;
    assign hz.ow_stall_id  = stall;
    assign hz.ow_flush_if  = flush;
    assign hz.ow_flush_id  = flush;
    assign hz.ow_state     = state;
    assign hz.ow_stall_cnt = stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Directed bench for pipe_hazard_ctl; expectations adapt to HAZARD_FWD_EN.
// Inputs change 1ns after the rising edge, outputs sampled 1ns later.
module tb_pipe_hazard_ctl;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   exp_scnt = 0;
    int   n;

    always #5 clk = ~clk;

    pipe_hazard_ctl_if bus ();

    pipe_hazard_ctl dut (
        .iw_clk (clk),
        .iw_rst (rst),
        .hz     (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.iw_id_valid        = 1'b0;
        bus.iw_id_has_src_gp   = 1'b0;
        bus.iw_id_src_gp       = 4'd0;
        bus.iw_id_tgt_gp_we    = 1'b0;
        bus.iw_id_tgt_gp       = 4'd0;
        bus.iw_id_has_src_sr   = 1'b0;
        bus.iw_id_src_sr       = 2'd0;
        bus.iw_id_tgt_sr_we    = 1'b0;
        bus.iw_id_tgt_sr       = 2'd0;
        bus.iw_id_is_load      = 1'b0;
        bus.iw_ex_branch_taken = 1'b0;
        bus.iw_mem_busy        = 1'b0;
    endtask

    task automatic ins(input logic [3:0] src, input logic use_src,
                       input logic [3:0] tgt, input logic we,
                       input logic ld);
        idle();
        bus.iw_id_valid      = 1'b1;
        bus.iw_id_has_src_gp = use_src;
        bus.iw_id_src_gp     = src;
        bus.iw_id_tgt_gp_we  = we;
        bus.iw_id_tgt_gp     = tgt;
        bus.iw_id_is_load    = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_scnt = 0;
    endtask

    // Counts stalled cycles of the held ID instruction, then lets it issue.
    task automatic count_stalls(output int cnt);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (!bus.ow_stall_id) break;
            cnt++;
            tick();
        end
        tick();
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        bus.iw_ex_branch_taken = 1'b1;
        bus.iw_mem_busy        = 1'b1;
        bus.iw_id_valid        = 1'b1;
        #2;
        chk("rst_flush_if", bus.ow_flush_if, 0);
        chk("rst_flush_id", bus.ow_flush_id, 0);
        chk("rst_stall_if", bus.ow_stall_if, 0);
        chk("rst_stall_id", bus.ow_stall_id, 0);
        chk("rst_state", bus.ow_state, 0);
        chk("rst_scnt", bus.ow_stall_cnt, 0);
        idle();
        tick();
        rst = 1'b0;

        // ALU write then dependent read; also self-dependency does not block
        ins(4'd3, 1'b1, 4'd3, 1'b1, 1'b0);
        #1 chk("self_haz", bus.ow_stall_id, 0);
        tick();
        ins(4'd3, 1'b1, 4'd0, 1'b0, 1'b0);
        count_stalls(n);
        chk("alu_stalls", n, FWD ? 0 : 3);
        exp_scnt += FWD ? 0 : 3;
        #1 chk("alu_scnt", bus.ow_stall_cnt, exp_scnt);

        // Load write then dependent read
        do_reset();
        ins(4'd0, 1'b0, 4'd5, 1'b1, 1'b1);
        tick();
        ins(4'd5, 1'b1, 4'd0, 1'b0, 1'b0);
        count_stalls(n);
        chk("load_stalls", n, FWD ? 2 : 4);
        exp_scnt += FWD ? 2 : 4;
        #1 chk("load_scnt", bus.ow_stall_cnt, exp_scnt);

        // SR load write then SR read
        idle();
        bus.iw_id_valid     = 1'b1;
        bus.iw_id_tgt_sr_we = 1'b1;
        bus.iw_id_tgt_sr    = 2'd1;
        bus.iw_id_is_load   = 1'b1;
        tick();
        idle();
        bus.iw_id_valid      = 1'b1;
        bus.iw_id_has_src_sr = 1'b1;
        bus.iw_id_src_sr     = 2'd1;
        count_stalls(n);
        chk("sr_stalls", n, FWD ? 2 : 4);
        exp_scnt += FWD ? 2 : 4;

        // Single branch: flushed writer of r7 must not reach scoreboard
        ins(4'd0, 1'b0, 4'd7, 1'b1, 1'b0);
        bus.iw_ex_branch_taken = 1'b1;
        #1;
        chk("br1_flush_if", bus.ow_flush_if, 1);
        chk("br1_flush_id", bus.ow_flush_id, 1);
        chk("br1_stall", bus.ow_stall_id, 0);
        chk("br1_state0", bus.ow_state, 0);
        tick();
        idle();
        #1;
        chk("br1_flush2", bus.ow_flush_id, 1);
        chk("br1_state2", bus.ow_state, 2);
        tick();
        #1;
        chk("br1_done", bus.ow_flush_if, 0);
        chk("br1_state_run", bus.ow_state, 0);
        ins(4'd7, 1'b1, 4'd0, 1'b0, 1'b0);
        count_stalls(n);
        chk("br1_r7_clean", n, 0);

        // Second branch in the flush cycle stretches the window
        n = 0;
        for (int k = 0; k < 6; k++) begin
            bus.iw_ex_branch_taken = (k < 2);
            #1;
            if (bus.ow_flush_if) n++;
            tick();
        end
        idle();
        chk("br2_flush_cycles", n, 3);

        // Memory wait during a hazard freezes the scoreboard
        ins(4'd0, 1'b0, 4'd2, 1'b1, FWD);
        tick();
        ins(4'd2, 1'b1, 4'd0, 1'b0, 1'b0);
        #1 chk("mw_c1_stall", bus.ow_stall_id, 1);
        tick();
        #1 chk("mw_haz_state", bus.ow_state, 1);
        bus.iw_mem_busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("mw_busy_stall", bus.ow_stall_if, 1);
            chk("mw_busy_state", bus.ow_state, (k == 0) ? 1 : 3);
            tick();
        end
        bus.iw_mem_busy = 1'b0;
        #1;
        chk("mw_exit_state", bus.ow_state, 3);
        chk("mw_exit_stall", bus.ow_stall_id, 1);
        tick();
        #1 chk("mw_haz_resume", bus.ow_state, 1);
        count_stalls(n);
        chk("mw_tail_stalls", n, FWD ? 0 : 1);
        exp_scnt += 7 + (FWD ? 0 : 1);
        #1 chk("mw_scnt", bus.ow_stall_cnt, exp_scnt);

        // Branch and hazard together: flush wins, no issue
        do_reset();
        ins(4'd0, 1'b0, 4'd4, 1'b1, 1'b1);
        tick();
        ins(4'd4, 1'b1, 4'd9, 1'b1, 1'b0);
        bus.iw_ex_branch_taken = 1'b1;
        #1;
        chk("bh_flush_id", bus.ow_flush_id, 1);
        chk("bh_stall_id", bus.ow_stall_id, 0);
        chk("bh_stall_if", bus.ow_stall_if, 0);
        tick();
        idle();
        #1 chk("bh_state", bus.ow_state, 2);
        tick();
        ins(4'd9, 1'b1, 4'd0, 1'b0, 1'b0);
        count_stalls(n);
        chk("bh_r9_clean", n, 0);
        #1 chk("bh_scnt", bus.ow_stall_cnt, 0);

        // Reset pulse in HAZ clears everything at once
        do_reset();
        ins(4'd0, 1'b0, 4'd3, 1'b1, 1'b1);
        tick();
        ins(4'd3, 1'b1, 4'd0, 1'b0, 1'b0);
        #1 chk("rh_stall", bus.ow_stall_id, 1);
        tick();
        #1;
        chk("rh_state_haz", bus.ow_state, 1);
        chk("rh_stall2", bus.ow_stall_id, 1);
        #1 rst = 1'b1;
        #1;
        chk("rh_async_stall", bus.ow_stall_id, 0);
        chk("rh_async_flush", bus.ow_flush_if, 0);
        chk("rh_async_state", bus.ow_state, 0);
        chk("rh_async_scnt", bus.ow_stall_cnt, 0);
        tick();
        rst = 1'b0;
        count_stalls(n);
        chk("rh_r3_clean", n, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
